// File: rtl/divider_v2_if.sv
// Digit-serial port bundle for divider_v2: operand digits and enable in, quotient digit out.
// Digit encoding {plus,minus}: 10 = +1, 01 = -1, 00/11 = 0.
`timescale 1ns/1ps
interface divider_v2_if;
  logic [1:0] x_value;
  logic [1:0] d_value;
  logic       enable;
  logic [1:0] q_value;

  modport master (output x_value, output d_value, output enable, input q_value);
  modport slave  (input x_value, input d_value, input enable, output q_value);
endinterface

// File: rtl/divider_v2.sv
// divider_v2: radix-2 online (MSD-first) signed-digit divider, q = x/d.
// One x and one d digit are consumed per enabled clock. Quotient digits
// leave DELTA+1 enabled edges after the first input digit; frames of
// N+DELTA steps run back to back.
// Optional build macro DIV_OUT_REG_EN adds one more output register on
// q_value (latency DELTA+2); frame timing is otherwise unchanged.
`timescale 1ns/1ps
module divider_v2 #(
  parameter int N      = 16,
  parameter int DELTA  = 4,
  parameter int W_FRAC = N + DELTA + 3
) (
  input  logic         clk,
  input  logic         asyn_reset,
  divider_v2_if.slave  dif
);

  localparam int STEPS = N + DELTA;
  localparam int W     = W_FRAC + 3;
  localparam int CNT_W = $clog2(STEPS);
  localparam int SH_W  = $clog2(W_FRAC + DELTA + 1);

  localparam logic signed [W-1:0] LSB_ONE = W'(1);
  // Weight of one input digit after the 2^-DELTA online scaling.
  localparam logic signed [W-1:0] X_ULP   = LSB_ONE <<< (W_FRAC - DELTA);

  // Signed-digit times magnitude: +mag, -mag or zero.
  function automatic logic signed [W-1:0] scale(input logic [1:0] dg,
                                                input logic signed [W-1:0] mag);
    case (dg)
      2'b10:   return mag;
      2'b01:   return -mag;
      default: return '0;
    endcase
  endfunction

  // Quotient digit selection on v truncated to two fractional bits.
  // The digit is mirrored for a negative divisor so that q*D always
  // pulls the residual back towards zero.
  function automatic logic [1:0] sel_digit(input logic signed [W-1:0] v,
                                           input logic d_neg);
    logic signed [W-1:0] t;
    logic [1:0]          q;
    t = v >>> (W_FRAC - 2);
    if (t >= LSB_ONE)       q = 2'b10;
    else if (t < -LSB_ONE)  q = 2'b01;
    else                    q = 2'b00;
    return d_neg ? {q[0], q[1]} : q;
  endfunction

  // step_p0 holds j-1; q_acc_p0 is the quotient accumulated so far (Q_(i-1)).
  logic [CNT_W-1:0]    step_p0;
  logic signed [W-1:0] w_p0;
  logic signed [W-1:0] d_p0;
  logic signed [W-1:0] q_acc_p0;
  logic [1:0]          q_p0;

  logic                in_digits;
  logic                sel_phase;
  logic                last_step;
  logic [SH_W-1:0]     sh_j;
  logic [SH_W-1:0]     sh_i;
  logic signed [W-1:0] x_term;
  logic signed [W-1:0] dq_term;
  logic signed [W-1:0] d_next;
  logic signed [W-1:0] v;
  logic signed [W-1:0] w_next;
  logic signed [W-1:0] q_acc_next;
  logic [1:0]          qs;

  // Recurrence for step j: accumulate D, form v, pick q_i, update residual.
  always_comb begin
    in_digits  = (step_p0 < CNT_W'(N));
    sel_phase  = (step_p0 >= CNT_W'(DELTA));
    last_step  = (step_p0 == CNT_W'(STEPS - 1));
    sh_j       = SH_W'(W_FRAC - 1) - SH_W'(step_p0);
    sh_i       = SH_W'(W_FRAC - 1 + DELTA) - SH_W'(step_p0);
    x_term     = '0;
    dq_term    = '0;
    d_next     = d_p0;
    if (in_digits) begin
      x_term  = scale(dif.x_value, X_ULP);
      dq_term = scale(dif.d_value, q_acc_p0 >>> DELTA);
      d_next  = d_p0 + scale(dif.d_value, LSB_ONE << sh_j);
    end
    v          = (w_p0 <<< 1) + x_term - dq_term;
    qs         = sel_phase ? sel_digit(v, d_next[W-1]) : 2'b00;
    w_next     = v - scale(qs, d_next);
    q_acc_next = q_acc_p0 + scale(qs, LSB_ONE << sh_i);
  end

  // ---- stage p0: iteration state and selected quotient digit ----
  // Advance one step per enabled clock; wrap and clear at end of frame.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      step_p0  <= '0;
      w_p0     <= '0;
      d_p0     <= '0;
      q_acc_p0 <= '0;
      q_p0     <= 2'b00;
    end else if (dif.enable) begin
      q_p0 <= qs;
      if (last_step) begin
        step_p0  <= '0;
        w_p0     <= '0;
        d_p0     <= '0;
        q_acc_p0 <= '0;
      end else begin
        step_p0  <= step_p0 + CNT_W'(1);
        w_p0     <= w_next;
        d_p0     <= d_next;
        q_acc_p0 <= q_acc_next;
      end
    end
  end

`ifdef DIV_OUT_REG_EN
  // ---- stage p1: extra output register ----
  logic [1:0] q_p1;

  // Delay the quotient digit by one enabled clock.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)      q_p1 <= 2'b00;
    else if (dif.enable) q_p1 <= q_p0;
  end

  assign dif.q_value = q_p1;
`else
  assign dif.q_value = q_p0;
`endif

endmodule

// File: tb/tb_divider_v2.sv
// Testbench for divider_v2: frames are issued by a stimulus process that
// pushes the exact quotient x/d into a scoreboard; a monitor rebuilds the
// quotient from the output digit stream and compares at end of frame.
`timescale 1ns/1ps
module tb_divider_v2;
  localparam int N     = 16;
  localparam int DELTA = 4;
  localparam int STEPS = N + DELTA;
`ifdef DIV_OUT_REG_EN
  localparam int LAT = DELTA + 1;
`else
  localparam int LAT = DELTA;
`endif

  typedef logic [1:0] digs_t [N];
  typedef struct {
    real   expv;
    real   tol;
    bit    mz;
    string name;
  } exp_t;

  logic clk;
  logic asyn_reset;
  divider_v2_if tif();

  divider_v2 #(.N(N), .DELTA(DELTA)) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .dif       (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input bit ok, input string nm, input string got, input string want);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, required %s", nm, got, want);
  endtask

  function automatic real dval(input logic [1:0] g);
    if (g == 2'b10) return 1.0;
    if (g == 2'b01) return -1.0;
    return 0.0;
  endfunction

  function automatic real to_real(input digs_t a);
    real r;
    r = 0.0;
    for (int k = 1; k <= N; k++) r += dval(a[k-1]) * (2.0 ** (-k));
    return r;
  endfunction

  function automatic logic [1:0] zero_digit();
    return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] rand_digit();
    return 2'($urandom);
  endfunction

  // Issue one frame (max_steps < STEPS aborts early); stall 5 cycles before step stall_at.
  task automatic drive_frame(input digs_t xs, input digs_t ds, input string nm,
                             input bit mz, input int stall_at, input int max_steps);
    exp_t e;
    e.expv = to_real(xs) / to_real(ds);
    e.tol  = mz ? 0.0 : 2.0 ** (-N);
    e.mz   = mz;
    e.name = nm;
    sb.push_back(e);
    for (int j = 1; j <= max_steps; j++) begin
      if (j == stall_at) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          tif.enable  = 1'b0;
          tif.x_value = rand_digit();
          tif.d_value = rand_digit();
        end
      end
      @(negedge clk);
      tif.enable  = 1'b1;
      tif.x_value = (j <= N) ? xs[j-1] : zero_digit();
      tif.d_value = (j <= N) ? ds[j-1] : zero_digit();
    end
  endtask

  task automatic clear_digs(output digs_t a);
    for (int k = 0; k < N; k++) a[k] = zero_digit();
  endtask

  // Random frame with |x| < 1/4 and a normalized divisor of either sign.
  task automatic rand_frame(output digs_t xs, output digs_t ds);
    logic [1:0] s;
    s = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < N; k++) xs[k] = (k < 2) ? zero_digit() : rand_digit();
    ds[0] = s;
    if ($urandom_range(0, 1) == 1) begin
      for (int k = 1; k < N; k++) ds[k] = (k == 1) ? s : rand_digit();
    end else begin
      for (int k = 1; k < N; k++)
        ds[k] = (k == 1 || $urandom_range(0, 1) == 0) ? zero_digit() : s;
    end
  endtask

  // Monitor: sample after each rising edge, rebuild the quotient per frame.
  int         mon_e = 0;
  int         mon_nz = 0;
  real        mon_acc = 0.0;
  logic [1:0] prev_q = 2'b00;

  initial begin
    logic       rs, en;
    logic [1:0] q;
    int         p;
    exp_t       ex;
    real        diff;
    forever begin
      @(posedge clk);
      rs = asyn_reset;
      en = tif.enable;
      #1;
      q = tif.q_value;
      check(q != 2'b11, "q_encoding", $sformatf("%b", q), "not 11");
      if (rs) begin
        mon_e = 0; mon_acc = 0.0; mon_nz = 0;
        check(q == 2'b00, "reset_q", $sformatf("%b", q), "00");
      end else if (!en) begin
        check(q == prev_q, "stall_hold", $sformatf("%b", q), $sformatf("%b", prev_q));
      end else begin
        mon_e++;
        if (mon_e <= LAT) begin
          check(q == 2'b00, "startup_zero", $sformatf("%b", q), "00");
        end else begin
          p = (mon_e - LAT - 1) % STEPS + 1;
          if (p > N) begin
            check(q == 2'b00, "gap_zero", $sformatf("%b", q), "00");
          end else begin
            if (p == 1) begin mon_acc = 0.0; mon_nz = 0; end
            mon_acc += dval(q) * (2.0 ** (-p));
            if (q != 2'b00) mon_nz++;
            if (p == N) begin
              if (sb.size() == 0) begin
                check(1'b0, "sb_underflow", "frame end", "expected entry");
              end else begin
                ex = sb.pop_front();
                diff = mon_acc - ex.expv;
                if (diff < 0.0) diff = -diff;
                check(diff <= ex.tol, ex.name, $sformatf("%0.9f", mon_acc),
                      $sformatf("%0.9f +/- %0.9f", ex.expv, ex.tol));
                if (ex.mz)
                  check(mon_nz == 0, {ex.name, "_digits"}, $sformatf("%0d nonzero", mon_nz), "0 nonzero");
              end
            end
          end
        end
      end
      prev_q = q;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    digs_t xs, ds, xe, de;
    asyn_reset  = 1'b1;
    tif.enable  = 1'b0;
    tif.x_value = 2'b00;
    tif.d_value = 2'b00;
    // Reset held 3 cycles with random digits and enable high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tif.enable  = 1'b1;
      tif.x_value = rand_digit();
      tif.d_value = rand_digit();
    end
    @(negedge clk);
    asyn_reset = 1'b0;
    tif.enable = 1'b0;

    // 1/4 / 1/2 = 1/2
    clear_digs(xs); clear_digs(ds);
    xs[1] = 2'b10; ds[0] = 2'b10;
    drive_frame(xs, ds, "q_1_4_div_1_2", 1'b0, 0, STEPS);
    // (1/2 - 1/4) / 3/4 = 1/3
    clear_digs(xs); clear_digs(ds);
    xs[0] = 2'b10; xs[1] = 2'b01; ds[0] = 2'b10; ds[1] = 2'b10;
    drive_frame(xs, ds, "q_1_4_div_3_4", 1'b0, 0, STEPS);
    // -1/2 / 3/4 = -2/3
    clear_digs(xs); clear_digs(ds);
    xs[0] = 2'b01; ds[0] = 2'b10; ds[1] = 2'b10;
    drive_frame(xs, ds, "q_m1_2_div_3_4", 1'b0, 0, STEPS);
    // 0 / 1/2: every digit zero
    clear_digs(xs); clear_digs(ds);
    ds[0] = 2'b10;
    drive_frame(xs, ds, "q_zero", 1'b1, 0, STEPS);
    // Same random operands unstalled, then stalled mid-frame.
    rand_frame(xe, de);
    drive_frame(xe, de, "q_unstalled", 1'b0, 0, STEPS);
    drive_frame(xe, de, "q_stalled", 1'b0, 8, STEPS);
    for (int f = 0; f < 8; f++) begin
      rand_frame(xs, ds);
      drive_frame(xs, ds, $sformatf("q_rand%0d", f), 1'b0,
                  (f % 2 == 1) ? int'($urandom_range(2, STEPS)) : 0, STEPS);
    end
    // Abort a frame at step 10, then 3/8 / 1/2 = 3/4.
    rand_frame(xs, ds);
    drive_frame(xs, ds, "q_aborted", 1'b0, 0, 10);
    @(negedge clk);
    asyn_reset = 1'b1;
    sb.delete();
    tif.x_value = rand_digit();
    tif.d_value = rand_digit();
    @(negedge clk);
    @(negedge clk);
    asyn_reset = 1'b0;
    tif.enable = 1'b0;
    clear_digs(xs); clear_digs(ds);
    xs[1] = 2'b10; xs[2] = 2'b10; ds[0] = 2'b10;
    drive_frame(xs, ds, "q_3_8_div_1_2", 1'b0, 0, STEPS);
    // Drain the output pipeline.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tif.enable  = 1'b1;
      tif.x_value = 2'b00;
      tif.d_value = 2'b00;
    end
    @(negedge clk);
    tif.enable = 1'b0;
    repeat (3) @(negedge clk);
    check(sb.size() == 0, "sb_drained", $sformatf("%0d left", sb.size()), "0 left");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
